// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver that samples rx_in at the centre of each bit.
// Ports: clk (rising edge), reset (async, active-low), rx_in (idle-high serial line),
//        rx_data (last good byte), rx_valid (1-cycle pulse when rx_data updates),
//        frame_error (1-cycle pulse when the stop bit is low), busy (receiver not idle).
module uart_receiver #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUDRATE = 57600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state, state_n;
    logic          sync1, rx_s, rx_p;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, idx_n;
    logic [7:0]    shreg, sh_n, data_n;
    logic          valid_n, err_n;

    assign busy = state != S_IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            sync1       <= 1'b1;
            rx_s        <= 1'b1;
            rx_p        <= 1'b1;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            sync1       <= rx_in;
            rx_s        <= sync1;
            rx_p        <= rx_s;
            cnt         <= cnt_n;
            bit_idx     <= idx_n;
            shreg       <= sh_n;
            rx_data     <= data_n;
            rx_valid    <= valid_n;
            frame_error <= err_n;
        end
    end

    // Only a falling edge seen while idle starts a frame, so a line held low
    // after a frame error must go high and fall again before re-arming.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = bit_idx;
        sh_n    = shreg;
        data_n  = rx_data;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n   = '0;
                state_n = (rx_p & ~rx_s) ? S_START : S_IDLE;
            end
            S_START: if (cnt == HALF_M1) begin
                state_n = rx_s ? S_IDLE : S_DATA;
                cnt_n   = '0;
                idx_n   = '0;
            end
            S_DATA: if (cnt == FULL_M1) begin
                sh_n    = {rx_s, shreg[7:1]};
                idx_n   = bit_idx + 3'd1;
                cnt_n   = '0;
                state_n = (bit_idx == 3'd7) ? S_STOP : S_DATA;
            end
            S_STOP: if (cnt == FULL_M1) begin
                state_n = S_IDLE;
                cnt_n   = '0;
                data_n  = rx_s ? shreg : rx_data;
                valid_n = rx_s;
                err_n   = ~rx_s;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed self-checking bench for uart_receiver at 50 clocks per bit.
module tb_uart_receiver;
    localparam int W = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_error, busy;

    int errors = 0, checks = 0;
    int cyc = 0, nvalid = 0, nerr = 0, viol = 0, busy_tot = 0;
    int vt [64];
    logic [7:0] vd [64];
    logic pv = 1'b0, pe = 1'b0;

    uart_receiver #(.CLK_FREQ(5_000_000), .BAUDRATE(100_000)) dut (
        .clk(clk), .reset(reset), .rx_in(rx_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (rx_valid) begin
            if (nvalid < 64) begin
                vt[nvalid] = cyc;
                vd[nvalid] = rx_data;
            end
            nvalid++;
        end
        if (frame_error) nerr++;
        if ((rx_valid && frame_error) || (rx_valid && pv) || (frame_error && pe)) viol++;
        pv = rx_valid;
        pe = frame_error;
        if (busy) busy_tot++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic level(input logic v, input int n);
        @(negedge clk) rx_in = v;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int w, input int nstop, input logic stop_v);
        level(1'b0, w);
        for (int i = 0; i < 8; i++) level(b[i], w);
        for (int i = 0; i < nstop; i++) level(stop_v, w);
    endtask

    int v0, e0, b0, d;

    initial begin
        repeat (4) @(negedge clk);
        #1;
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 0);
        check("rst_ferr", frame_error, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        level(1'b1, 20);

        v0 = nvalid; e0 = nerr;
        send_byte(8'h55, W, 1, 1'b1);
        level(1'b1, 20);
        check("b55_count", nvalid - v0, 1);
        check("b55_data", rx_data, 8'h55);
        check("b55_ferr", nerr - e0, 0);
        check("b55_busy", busy, 0);

        v0 = nvalid;
        send_byte(8'hA3, W, 2, 1'b1);
        send_byte(8'h00, W, 2, 1'b1);
        send_byte(8'hFF, W, 2, 1'b1);
        level(1'b1, 50);
        check("b2b_count", nvalid - v0, 3);
        check("b2b_d0", vd[v0], 8'hA3);
        check("b2b_d1", vd[v0 + 1], 8'h00);
        check("b2b_d2", vd[v0 + 2], 8'hFF);
        for (int k = 0; k < 2; k++) begin
            d = vt[v0 + k + 1] - vt[v0 + k];
            check("b2b_gap", (d >= 11 * W - 2 && d <= 11 * W + 2) ? 11 * W : d, 11 * W);
        end

        v0 = nvalid; e0 = nerr;
        send_byte(8'h3C, W, 1, 1'b0);
        level(1'b0, 20 * W);
        check("ferr_count", nerr - e0, 1);
        check("ferr_novalid", nvalid - v0, 0);
        check("ferr_keep", rx_data, 8'hFF);
        check("break_busy", busy, 0);
        level(1'b1, 100);
        send_byte(8'h81, W, 1, 1'b1);
        level(1'b1, 20);
        check("rearm_count", nvalid - v0, 1);
        check("rearm_data", rx_data, 8'h81);
        check("rearm_ferr", nerr - e0, 1);

        v0 = nvalid; e0 = nerr; b0 = busy_tot;
        level(1'b0, 10);
        level(1'b1, 100);
        check("glitch_pulses", (nvalid - v0) + (nerr - e0), 0);
        d = busy_tot - b0;
        check("glitch_busy", (d >= W / 2 - 1 && d <= W / 2 + 1) ? W / 2 : d, W / 2);

        level(1'b0, W);
        for (int i = 0; i < 4; i++) level(logic'((8'h96 >> i) & 8'h01), W);
        level(1'b0, 20);
        @(negedge clk) reset = 1'b0;
        #1;
        check("arst_data", rx_data, 8'h00);
        check("arst_busy", busy, 0);
        check("arst_valid", rx_valid, 0);
        check("arst_ferr", frame_error, 0);
        rx_in = 1'b1;
        v0 = nvalid; e0 = nerr;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        level(1'b1, 200);
        check("arst_nopulse", (nvalid - v0) + (nerr - e0), 0);
        send_byte(8'h5A, W, 1, 1'b1);
        level(1'b1, 20);
        check("arst_after", rx_data, 8'h5A);

        v0 = nvalid; e0 = nerr;
        send_byte(8'hC7, W - 1, 1, 1'b1);
        level(1'b1, 50);
        check("fast2_count", nvalid - v0, 1);
        check("fast2_data", rx_data, 8'hC7);

        v0 = nvalid; e0 = nerr;
        send_byte(8'hC7, W - 3, 1, 1'b1);
        send_byte(8'h00, W - 3, 1, 1'b1);
        level(1'b1, 300);
        check("fast6_bad", (nerr > e0 || rx_data != 8'hC7) ? 1 : 0, 1);
        check("fast6_idle", busy, 0);
        v0 = nvalid;
        send_byte(8'h3E, W, 1, 1'b1);
        level(1'b1, 20);
        check("fast6_next_count", nvalid - v0, 1);
        check("fast6_next_data", rx_data, 8'h3E);

        check("pulse_rules", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART 8N1 serial receiver: the receive-side counterpart of the team's UART transmitter, running on the same clock and baud parameters.
- Samples the asynchronous rx line at the centre of each bit, LSB first, and returns each byte with a one-cycle valid pulse.
- Flags framing errors (stop bit sampled low) and ignores glitches shorter than half a bit.
- Sits between the board RX pin and the byte-consuming logic (command parser / loopback FIFO).

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUDRATE, 57600, serial bit rate in bit/s.
- Derived: CLKS_PER_BIT = CLK_FREQ/BAUDRATE (integer divide, 1736 at defaults); HALF_BIT = CLKS_PER_BIT/2 (868).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- rx_in  input  1  serial line, asynchronous to clk, idle high.
- rx_data  output  8  last correctly received byte; holds its value until the next good byte.
- rx_valid  output  1  one-cycle pulse: rx_data was just updated.
- frame_error  output  1  one-cycle pulse: stop bit sampled low; byte discarded.
- busy  output  1  high in any state other than S_IDLE.

Behaviour:
- Reset is asynchronous and active-low; clock is clk.
  - On reset: state = S_IDLE, rx_data = 8'h00, rx_valid = 0, frame_error = 0, busy = 0.
  - Synchronizer flops and the previous-sample register reset to 1.
  - Bit counter and baud counter reset to 0.
- Input conditioning:
  - rx_in passes through a 2-flop synchronizer, giving rx_s.
  - A 1-flop delayed copy, rx_p, supports edge detection.
  - Falling edge = rx_p & ~rx_s.
  - All sampling uses rx_s only.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Cleared on every state transition; increments in S_START, S_DATA and S_STOP.
- State machine (one-hot or enum, implementer's choice; illegal states recover to S_IDLE):
  - S_IDLE: wait for a falling edge, then go to S_START with the counter cleared.
  - S_START: when the counter reaches HALF_BIT-1, sample rx_s.
    - rx_s = 0: go to S_DATA, counter cleared, bit index 0.
    - rx_s = 1: false start (glitch); return to S_IDLE with no output pulse.
  - S_DATA: when the counter reaches CLKS_PER_BIT-1 (centre of a data bit), shift rx_s into a shift register MSB-side, so bit 0 arrives first.
    - Increment the bit index and clear the counter.
    - After the 8th sample (index 7), go to S_STOP.
  - S_STOP: when the counter reaches CLKS_PER_BIT-1, sample rx_s.
    - rx_s = 1: load rx_data from the shift register and pulse rx_valid for exactly one cycle.
    - rx_s = 0: pulse frame_error for exactly one cycle; rx_data is unchanged.
    - In both cases go to S_IDLE in the same cycle.
- Re-arm rule:
  - Only one stop bit is checked; extra stop bits (the transmitter sends two) are treated as idle.
  - A new start is accepted on the first falling edge seen in S_IDLE.
  - After a frame error with the line held low (break), no restart occurs until the line returns high and then falls again. This follows from the edge-detect rule.
- Falling edges on rx_s outside S_IDLE are ignored.
- Latency: rx_valid rises HALF_BIT + 9*CLKS_PER_BIT cycles (±1) after the first S_START cycle, plus 3 cycles of sync/edge delay from the rx_in transition.
- rx_valid and frame_error are registered and mutually exclusive. Neither is ever high for two consecutive cycles.
- Reset asserted mid-frame aborts immediately: all outputs go to their reset values and no pulse is emitted.

Test Plan:
- 0x55 at CLK_FREQ=100_000_000, BAUDRATE=57600, bits 1736 cycles wide, 1 stop bit -> exactly one rx_valid pulse, rx_data=8'h55, frame_error never high, busy low after the pulse.
- Back-to-back bytes 0xA3, 0x00, 0xFF with 2 stop bits each (transmitter loopback) -> three rx_valid pulses, rx_data sequence A3, 00, FF, pulses spaced 11*1736 cycles apart (±2).
- 0x3C with stop bit forced to 0 -> one frame_error pulse, no rx_valid, rx_data keeps its previous value. Line held low 20 bit times, then high, then a valid 0x81 -> rx_valid with rx_data=8'h81.
- rx_in low glitch of 400 cycles (< HALF_BIT) from idle -> returns to S_IDLE, no pulse, busy high for about 868 cycles only.
- Reset deasserted then reasserted (low) during bit 4 of 0x96 -> outputs go to reset values asynchronously. After release, a following valid 0x5A -> rx_data=8'h5A.
- Baud mismatch: transmitter at +2% rate sending 0xC7 -> received correctly. At +6% -> mismatch or frame_error reported, no hang; next correct-rate byte is received.
